// File: rtl/conv_requant_out.sv
`default_nettype none
// ============================================================================
// Module   : conv_requant_out
// Purpose  : Output stage of the 3x3 systolic convolution engine. Tracks the
//            raster position of the 32-bit signed result stream, drops the
//            warm-up border (row < 2 or col < 2), requantizes the kept results
//            to unsigned 8-bit (arithmetic shift + saturation) and buffers them
//            in a first-word fall-through FIFO with a valid/ready output.
// Options  : CONV_REQUANT_ROUND_EN - when defined, adds 2^(cfg_shift-1)
//            before the shift (round half up); otherwise plain floor shift.
// Revision : 1.0 - initial release
// ============================================================================
module conv_requant_out #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [31:0]                   in_pixel,
    input  logic [4:0]                    cfg_shift,
    output logic                          out_valid,
    output logic [7:0]                    out_data,
    input  logic                          out_ready,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_COL_W = $clog2(IMG_WIDTH);
    localparam int c_ROW_W = $clog2(IMG_HEIGHT);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);
    localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);
    localparam logic [c_COL_W-1:0] c_COL_KEEP = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_KEEP = c_ROW_W'(2);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // Raster position
    // ------------------------------------------------------------------------
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_keep;
    logic               w_last;

    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);
    // The first two rows/cols are produced while the line buffer and the
    // systolic pipe are still filling, so they carry no valid convolution.
    assign w_keep     = in_valid && (r_row >= c_ROW_KEEP) && (r_col >= c_COL_KEEP);
    assign w_last     = in_valid && w_row_last && w_col_last;

    // Advance col on every accepted beat, row on col wrap, both wrap at frame end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : (r_row + c_ROW_ONE);
            end else begin
                r_col <= r_col + c_COL_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage S1: sign-extend, optional rounding, arithmetic shift
    // ------------------------------------------------------------------------
    // 33 bits so that adding the rounding term to 0x7FFFFFFF cannot wrap.
    logic signed [32:0] w_ext;
    logic signed [32:0] w_sum;
    logic signed [32:0] w_shifted;

    assign w_ext = {in_pixel[31], in_pixel};

`ifdef CONV_REQUANT_ROUND_EN
    logic signed [32:0] w_round;
    assign w_round = (cfg_shift == 5'd0) ? 33'sd0 : (33'sd1 <<< (cfg_shift - 5'd1));
    assign w_sum   = w_ext + w_round;
`else
    assign w_sum   = w_ext;
`endif

    assign w_shifted = w_sum >>> cfg_shift;

    logic signed [32:0] r_s1_val;
    logic               r_s1_keep;
    logic               r_s1_last;

    // Register the shifted value together with its keep and end-of-frame tags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_val  <= '0;
            r_s1_keep <= 1'b0;
            r_s1_last <= 1'b0;
        end else begin
            r_s1_val  <= w_shifted;
            r_s1_keep <= w_keep;
            r_s1_last <= w_last;
        end
    end

    // ------------------------------------------------------------------------
    // Stage S2: saturate to the unsigned 8-bit pixel range
    // ------------------------------------------------------------------------
    logic [7:0] w_sat;

    // Clamp negatives to 0 and anything above 255 to 255
    always_comb begin
        w_sat = r_s1_val[7:0];
        if (r_s1_val[32]) begin
            w_sat = 8'd0;
        end else if (|r_s1_val[31:8]) begin
            w_sat = 8'hFF;
        end
    end

    logic [7:0] r_s2_data;
    logic       r_s2_keep;
    logic       r_s2_last;

    // Register the saturated pixel; it is offered to the FIFO next edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_data <= '0;
            r_s2_keep <= 1'b0;
            r_s2_last <= 1'b0;
        end else begin
            r_s2_data <= w_sat;
            r_s2_keep <= r_s1_keep;
            r_s2_last <= r_s1_last;
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------------
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_overflow;
    logic               r_frame_done;
    logic               w_push;
    logic               w_pop;

    assign out_valid = (r_level != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign w_pop     = out_valid && out_ready;
    // A full FIFO still takes the pixel when the head leaves in the same cycle.
    assign w_push    = r_s2_keep && ((r_level != c_LVL_FULL) || w_pop);

    // Storage array: no reset needed, contents are qualified by the level
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_s2_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo FIFO_DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Status: sticky drop flag and an end-of-frame pulse after the last beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (r_s2_keep && !w_push) begin
                r_overflow <= 1'b1;
            end
            r_frame_done <= r_s2_last;
        end
    end

    assign overflow   = r_overflow;
    assign frame_done = r_frame_done;
    assign level      = r_level;

endmodule

`default_nettype wire

// File: tb/tb_conv_requant_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_requant_out
// Purpose  : Self-checking bench for conv_requant_out. Instance A (4x4 frame)
//            runs a table of requantization vectors plus gapped-input and
//            mid-frame reset sequences; instance B (8x8 frame) covers FIFO
//            saturation, overflow and full-FIFO push/pop in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_requant_out;

`ifdef CONV_REQUANT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic [4:0]  cfg_shift;

    logic        a_rst_n, a_valid, a_ready, a_out_valid, a_frame_done, a_overflow;
    logic [31:0] a_pixel;
    logic [7:0]  a_out_data;
    logic [4:0]  a_level;

    logic        b_rst_n, b_valid, b_ready, b_out_valid, b_frame_done, b_overflow;
    logic [31:0] b_pixel;
    logic [7:0]  b_out_data;
    logic [4:0]  b_level;

    conv_requant_out #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .FIFO_DEPTH(16)) u_a (
        .clk(clk), .rst_n(a_rst_n), .in_valid(a_valid), .in_pixel(a_pixel),
        .cfg_shift(cfg_shift), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_ready(a_ready), .frame_done(a_frame_done), .overflow(a_overflow),
        .level(a_level)
    );

    conv_requant_out #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_valid), .in_pixel(b_pixel),
        .cfg_shift(cfg_shift), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_ready(b_ready), .frame_done(b_frame_done), .overflow(b_overflow),
        .level(b_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: record every accepted pixel and frame_done pulse
    logic [7:0] a_q[$];
    int         a_cq[$];
    int         fd_a = 0;
    logic [7:0] b_q[$];
    int         fd_b = 0;

    always @(negedge clk) begin
        if (a_out_valid && a_ready) begin
            a_q.push_back(a_out_data);
            a_cq.push_back(cyc);
        end
        if (a_frame_done) fd_a++;
        if (b_out_valid && b_ready) b_q.push_back(b_out_data);
        if (b_frame_done) fd_b++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Vector table: kept inputs (row2 col2, row2 col3, row3 col2, row3 col3)
    typedef struct {
        logic [4:0]       shift;
        logic [3:0][31:0] k;
        logic [3:0][7:0]  e;    // floor shift
        logic [3:0][7:0]  er;   // round half up
    } vec_t;

    localparam int NVEC = 6;
    vec_t tbl [NVEC];

    task automatic set_vec(input int i, input logic [4:0] s,
                           input logic [31:0] k0, input logic [31:0] k1,
                           input logic [31:0] k2, input logic [31:0] k3,
                           input int e0, input int e1, input int e2, input int e3,
                           input int r0, input int r1, input int r2, input int r3);
        tbl[i].shift = s;
        tbl[i].k[0] = k0; tbl[i].k[1] = k1; tbl[i].k[2] = k2; tbl[i].k[3] = k3;
        tbl[i].e[0] = 8'(e0); tbl[i].e[1] = 8'(e1); tbl[i].e[2] = 8'(e2); tbl[i].e[3] = 8'(e3);
        tbl[i].er[0] = 8'(r0); tbl[i].er[1] = 8'(r1); tbl[i].er[2] = 8'(r2); tbl[i].er[3] = 8'(r3);
    endtask

    // Drive one 4x4 frame into instance A; border beats carry their raster index
    task automatic run_a_frame(input int vi, input bit gapped, input string tag);
        int         kk;
        int         beat_q[$];
        logic [7:0] ev;
        a_q.delete();
        a_cq.delete();
        fd_a      = 0;
        kk        = 0;
        cfg_shift = tbl[vi].shift;
        a_ready   = 1'b1;
        for (int idx = 0; idx < 16; idx++) begin
            @(posedge clk); #1;
            a_valid = 1'b1;
            if ((idx / 4) >= 2 && (idx % 4) >= 2) begin
                a_pixel = tbl[vi].k[kk];
                kk++;
                beat_q.push_back(cyc);
            end else begin
                a_pixel = 32'(idx);
            end
            if (gapped) begin
                @(posedge clk); #1;
                a_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check($sformatf("%s count", tag), a_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            ev = ROUND ? tbl[vi].er[i] : tbl[vi].e[i];
            check($sformatf("%s pix%0d", tag, i),
                  (i < a_q.size()) ? int'(a_q[i]) : -1, int'(ev));
            check($sformatf("%s lat%0d", tag, i),
                  (i < a_cq.size()) ? (a_cq[i] - beat_q[i]) : -1, 3);
        end
        check($sformatf("%s frame_done", tag), fd_a, 1);
        check($sformatf("%s overflow", tag), int'(a_overflow), 0);
        check($sformatf("%s level", tag), int'(a_level), 0);
    endtask

    // Full 8x8 frame into instance B, pixel value = raster index
    task automatic drive_b_frame();
        for (int idx = 0; idx < 64; idx++) begin
            @(posedge clk); #1;
            b_valid = 1'b1;
            b_pixel = 32'(idx);
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    // n-th kept pixel of the 8x8 frame (6 kept per row from row 2)
    function automatic int exp_b(input int n);
        return (2 + n / 6) * 8 + (2 + n % 6);
    endfunction

    task automatic reset_b();
        b_rst_n = 1'b0;
        b_valid = 1'b0;
        b_ready = 1'b0;
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        b_q.delete();
        fd_b = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int t;

        set_vec(0, 5'd0,  32'd10, 32'd11, 32'd14, 32'd15,
                10, 11, 14, 15,   10, 11, 14, 15);
        set_vec(1, 5'd4,  32'd40, 32'hFFFF_FFD8, 32'd5000, 32'h7FFF_FFFF,
                2, 0, 255, 255,   3, 0, 255, 255);
        set_vec(2, 5'd0,  32'hFFFF_FFFF, 32'd255, 32'd256, 32'd0,
                0, 255, 255, 0,   0, 255, 255, 0);
        set_vec(3, 5'd8,  32'h0000_1234, 32'h8000_0000, 32'h0000_FFFF, 32'h0000_0180,
                18, 0, 255, 1,    18, 0, 255, 2);
        set_vec(4, 5'd31, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
                0, 0, 0, 0,       1, 0, 0, 0);
        set_vec(5, 5'd1,  32'd511, 32'd3, 32'hFFFF_FFFE, 32'd510,
                255, 1, 0, 255,   255, 2, 0, 255);

        cfg_shift = 5'd0;
        a_rst_n = 1'b0; a_valid = 1'b0; a_ready = 1'b0; a_pixel = '0;
        b_rst_n = 1'b0; b_valid = 1'b0; b_ready = 1'b0; b_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset a out_valid", int'(a_out_valid), 0);
        check("reset a level", int'(a_level), 0);
        check("reset a overflow", int'(a_overflow), 0);
        check("reset a frame_done", int'(a_frame_done), 0);
        check("reset b out_valid", int'(b_out_valid), 0);
        check("reset b level", int'(b_level), 0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Table-driven requantization frames, back-to-back input
        for (int v = 0; v < NVEC; v++) begin
            run_a_frame(v, 1'b0, $sformatf("vec%0d", v));
        end

        // Gapped input gives the same pixels and per-pixel latency
        run_a_frame(0, 1'b1, "gapped");

        // Mid-frame reset at row 2 with data buffered and in flight
        a_ready   = 1'b0;
        cfg_shift = 5'd0;
        for (int idx = 0; idx < 12; idx++) begin
            @(posedge clk); #1;
            a_valid = 1'b1;
            a_pixel = 32'(idx);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        check("prereset level", int'(a_level), 1);
        check("prereset out_valid", int'(a_out_valid), 1);
        a_rst_n = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        check("midreset out_valid", int'(a_out_valid), 0);
        check("midreset level", int'(a_level), 0);
        check("midreset overflow", int'(a_overflow), 0);
        repeat (5) @(posedge clk);
        #1;
        check("midreset in-flight dropped", int'(a_level), 0);
        run_a_frame(0, 1'b0, "postreset");

        // FIFO saturation: 36 kept pixels into 16 entries with the sink stalled
        reset_b();
        drive_b_frame();
        repeat (5) @(posedge clk);
        #1;
        check("sat level", int'(b_level), 16);
        check("sat overflow", int'(b_overflow), 1);
        check("sat out_valid", int'(b_out_valid), 1);
        check("sat frame_done", fd_b, 1);
        b_ready = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        check("drain count", b_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain pix%0d", i),
                  (i < b_q.size()) ? int'(b_q[i]) : -1, exp_b(i));
        end
        check("drain level", int'(b_level), 0);
        check("drain overflow sticky", int'(b_overflow), 1);

        // Full FIFO released exactly when the next kept pixel arrives
        reset_b();
        seen = 1'b0;
        fork
            drive_b_frame();
            begin
                for (t = 0; t < 200 && !seen; t++) begin
                    @(posedge clk); #1;
                    if (b_level == 5'd16) seen = 1'b1;
                end
                check("full reached", int'(seen), 1);
                if (seen) begin
                    b_ready = 1'b1;
                    @(negedge clk);
                    check("full push+pop level", int'(b_level), 16);
                    check("full push+pop overflow", int'(b_overflow), 0);
                    @(negedge clk);
                    check("full push+pop level2", int'(b_level), 16);
                end
            end
        join
        b_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("full order count", b_q.size(), 36);
        for (int i = 0; i < 36; i++) begin
            check($sformatf("full order pix%0d", i),
                  (i < b_q.size()) ? int'(b_q[i]) : -1, exp_b(i));
        end
        check("full overflow", int'(b_overflow), 0);
        check("full level end", int'(b_level), 0);
        check("full frame_done", fd_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_requant_out.md
Name: conv_requant_out

Overview:
- Downstream stage of the 3x3 systolic convolution engine.
- Consumes the engine's 32-bit signed result stream (valid-only, no backpressure) and tracks raster position.
- Discards border results produced while the line buffer and systolic pipe warm up.
- Requantizes kept results to unsigned 8-bit pixels (arithmetic shift plus saturation) and buffers them in a FIFO with a valid/ready output for the frame writer.

Parameters:
- IMG_WIDTH, 32, pixels per row; must match the engine's IMG_WIDTH; >= 3.
- IMG_HEIGHT, 32, rows per frame; >= 3.
- FIFO_DEPTH, 16, output FIFO entries; power of two, >= 4.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  engine result valid (engine out_valid).
- in_pixel  input  32  engine result, two's complement (engine out_pixel).
- cfg_shift  input  5  right-shift amount 0..31; held static for a whole frame.
- out_valid  output  1  FIFO head holds a pixel.
- out_data  output  8  requantized pixel at FIFO head.
- out_ready  input  1  consumer accepts the pixel when out_valid && out_ready.
- frame_done  output  1  one-cycle pulse after the last result of a frame is accepted.
- overflow  output  1  sticky flag: a kept pixel was dropped because the FIFO was full.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low at a clk edge) clears col, row, pipeline valids, FIFO pointers, level, frame_done, overflow and out_valid to 0.
- Reset mid-frame discards all in-flight and buffered data. out_data is don't-care while out_valid=0.
- Position counters:
  - col 0..IMG_WIDTH-1 increments on every in_valid beat; on wrap, col=0 and row increments.
  - row wraps IMG_HEIGHT-1 -> 0. Counters hold when in_valid=0.
- Keep rule: a beat is kept iff row>=2 && col>=2; all other beats are dropped silently. Kept pixels per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Stage S1 (registered):
  - Sign-extend in_pixel to 33 bits, optionally add the rounding term (see Optional Feature).
  - Arithmetic right shift by cfg_shift.
  - Register the result with keep_valid and a last flag (row=H-1 && col=W-1).
- Stage S2 (registered) saturates the shifted value: below 0 -> 0, above 255 -> 255, otherwise the low 8 bits.
  - If keep_valid: push to FIFO when level<FIFO_DEPTH or when a pop occurs in the same cycle; otherwise drop the pixel and set overflow=1.
  - overflow stays set until reset.
- frame_done pulses 1 in the cycle after S2 processes the last-flag beat, whether or not that beat was kept or pushed.
- Latency: an in_valid beat at edge N, kept, with the FIFO empty, gives out_valid=1 with its data after edge N+3.
  - One pixel per cycle is sustained when out_ready=1.
- FIFO behaviour:
  - First-word fall-through; out_data/out_valid reflect the head.
  - Pop only on out_valid && out_ready. out_ready while empty has no effect.
  - Simultaneous push and pop when full is legal: level unchanged, no overflow.
  - Simultaneous push and pop when empty: the pushed data appears on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- The block never stalls the input; there is no input ready signal.

Optional Feature:
- Macro CONV_REQUANT_ROUND_EN.
- Defined: before the shift, add 2^(cfg_shift-1) when cfg_shift>0 (round half up). The 33-bit intermediate prevents wrap at 0x7FFFFFFF.
- Undefined: plain arithmetic shift (floor toward minus infinity); no adder is instantiated.

Test Plan:
- W=4, H=4, shift=0, inputs 0..15 back-to-back, out_ready=1 -> outputs exactly 10, 11, 14, 15; frame_done one pulse; overflow=0.
- Shift=4, kept inputs 40, -40, 5000, 0x7FFFFFFF -> outputs 2, 0, 255, 255. With ROUND_EN the first becomes 3 (40/16=2.5).
- out_ready=0, W=H=8 frame (36 kept), FIFO_DEPTH=16 -> level saturates at 16, overflow=1; releasing out_ready drains exactly 16 pixels, in order.
- Full FIFO with out_ready=1 and a push in the same cycle -> level stays 16, overflow stays 0, data order preserved.
- Assert rst_n=0 for one cycle mid-frame (row 2) -> out_valid=0, level=0, overflow=0 next cycle. The following frame starts at row=0, col=0 and yields the correct 4 pixels (W=H=4).
- Gapped input (in_valid toggling 1/0), W=H=4 -> same 4 outputs as back-to-back; each kept pixel appears 3 cycles after its beat.
